// File: rtl/redmule_tcdm_arbiter_if.sv
// Bus bundles around the RedMulE TCDM arbiter: the streamer side (three load streams plus
// the Z store stream) and the single shared TCDM port.
interface redmule_tcdm_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic [2:0]      ld_req;
    logic [3*AW-1:0] ld_addr;
    logic [2:0]      ld_gnt;
    logic [2:0]      ld_rvalid;
    logic [DW-1:0]   ld_rdata;
    logic            z_req;
    logic [AW-1:0]   z_addr;
    logic [DW-1:0]   z_data;
    logic [DW/8-1:0] z_be;
    logic            z_gnt;

    modport master (
        output ld_req, ld_addr, z_req, z_addr, z_data, z_be,
        input  ld_gnt, ld_rvalid, ld_rdata, z_gnt
    );

    modport slave (
        input  ld_req, ld_addr, z_req, z_addr, z_data, z_be,
        output ld_gnt, ld_rvalid, ld_rdata, z_gnt
    );
endinterface

interface redmule_tcdm_mem_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic            req;
    logic            wen;
    logic [AW-1:0]   add;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, wen, add, data, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wen, add, data, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/redmule_tcdm_arbiter.sv
// Shares one TCDM port between the X/W/Y load streams and the Z store stream, one grant per
// cycle, and routes in-order read responses back to the issuing load stream.
module redmule_tcdm_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned Z_STARVE  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          z_priority_i,
    redmule_tcdm_arbiter_if.slave         strm_if,
    redmule_tcdm_mem_if.master            tcdm_if,
    output logic                          busy_o
);
    localparam int unsigned PW = $clog2(MAX_OUTST);
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned SW = $clog2(Z_STARVE + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(Z_STARVE);
    localparam logic [1:0]    ID_Z       = 2'd3;

    typedef enum logic {
        ST_ARB,
        ST_DRAIN
    } state_e;

    state_e        r_state;
    logic [1:0]    r_rr;
    logic [SW-1:0] r_starve;
    logic [1:0]    r_fifo [MAX_OUTST];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [2:0]    w_ld_req;
    logic          w_z_req;
    logic [AW-1:0] w_ld_addr [3];
    logic          w_full;
    logic          w_eligible;
    logic          w_z_win;
    logic          w_ld_found;
    logic [1:0]    w_ld_pick;
    logic [1:0]    w_rr_cand;
    logic [1:0]    w_win_id;
    logic          w_req;
    logic          w_hs;
    logic          w_pop;
    logic [1:0]    w_head_id;
    logic [2:0]    w_ld_gnt;
    logic          w_z_gnt;
    logic [2:0]    w_ld_rvalid;

    function automatic logic [1:0] rrNext(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    assign w_ld_req = strm_if.ld_req;
    assign w_z_req  = strm_if.z_req;

    for (genvar g = 0; g < 3; g++) begin : g_addr
        assign w_ld_addr[g] = strm_if.ld_addr[g*AW +: AW];
    end

    assign w_full     = (r_count == FULL_CNT);
    assign w_eligible = !rst_i && (r_state == ST_ARB) && !w_full;
    assign w_z_win    = w_z_req && (z_priority_i || (r_starve == STARVE_MAX) || !(|w_ld_req));

    // Round-robin search starting at the pointer, wrapping X -> W -> Y -> X.
    always_comb begin
        w_ld_found = 1'b0;
        w_ld_pick  = 2'd0;
        w_rr_cand  = r_rr;
        for (int k = 0; k < 3; k++) begin
            if (!w_ld_found && w_ld_req[w_rr_cand]) begin
                w_ld_found = 1'b1;
                w_ld_pick  = w_rr_cand;
            end
            w_rr_cand = rrNext(w_rr_cand);
        end
    end

    assign w_req    = w_eligible && (w_z_win || w_ld_found);
    assign w_win_id = w_z_win ? ID_Z : w_ld_pick;
    assign w_hs     = w_req && tcdm_if.gnt;

    assign tcdm_if.req  = w_req;
    assign tcdm_if.wen  = w_req && !w_z_win;
    assign tcdm_if.add  = !w_req ? '0 : (w_z_win ? strm_if.z_addr : w_ld_addr[w_ld_pick]);
    assign tcdm_if.data = (w_req && w_z_win) ? strm_if.z_data : '0;
    assign tcdm_if.be   = !w_req ? '0 : (w_z_win ? strm_if.z_be : '1);

    always_comb begin
        w_ld_gnt = 3'b000;
        if (w_hs && !w_z_win) begin
            w_ld_gnt[w_ld_pick] = 1'b1;
        end
    end

    assign w_z_gnt        = w_hs && w_z_win;
    assign strm_if.ld_gnt = w_ld_gnt;
    assign strm_if.z_gnt  = w_z_gnt;

    // A response with nothing outstanding is dropped rather than corrupting the FIFO.
    assign w_head_id = r_fifo[r_rptr];
    assign w_pop     = !rst_i && tcdm_if.rvalid && (r_count != '0);

    always_comb begin
        w_ld_rvalid = 3'b000;
        if (w_pop && (w_head_id != ID_Z)) begin
            w_ld_rvalid[w_head_id] = 1'b1;
        end
    end

    assign strm_if.ld_rvalid = w_ld_rvalid;
    assign strm_if.ld_rdata  = tcdm_if.rdata;
    assign busy_o            = !rst_i && ((r_count != '0) || (r_state == ST_DRAIN));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_ARB;
            r_rr     <= 2'd0;
            r_starve <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wptr] <= w_win_id;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_ARB: begin
                    if (w_hs && !w_z_win) begin
                        r_rr <= rrNext(w_ld_pick);
                    end
                    if (!w_z_req || w_z_gnt) begin
                        r_starve <= '0;
                    end else if (r_starve != STARVE_MAX) begin
                        r_starve <= r_starve + 1'b1;
                    end
                    if (clear_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leaving drain restarts arbitration from a clean slate.
                    if ((r_count == '0) && !clear_i) begin
                        r_state  <= ST_ARB;
                        r_rr     <= 2'd0;
                        r_starve <= '0;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        tcdm_if.rvalid |-> (r_count != '0));

    for (genvar g = 0; g < 3; g++) begin : g_hold
        a_ld_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (w_ld_req[g] && $past(w_ld_req[g] && !w_ld_gnt[g])) |-> $stable(w_ld_addr[g]));
    end

    a_z_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_z_req && $past(w_z_req && !w_z_gnt))
            |-> $stable({strm_if.z_addr, strm_if.z_data, strm_if.z_be}));
endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed bench for redmule_tcdm_arbiter: expected grants and responses are queued as each
// step is driven and compared as the shared port and response path produce them.
module tb_redmule_tcdm_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    localparam logic [AW-1:0]   ADDR_X = 32'h0000_1000;
    localparam logic [AW-1:0]   ADDR_W = 32'h0000_2040;
    localparam logic [AW-1:0]   ADDR_Y = 32'h0000_3080;
    localparam logic [AW-1:0]   ADDR_Z = 32'h0000_40C0;
    localparam logic [DW-1:0]   Z_DATA = 32'hCAFE_F00D;
    localparam logic [DW/8-1:0] Z_BE   = 4'b1010;

    logic clk_i = 1'b0;
    logic rst_i;
    logic clear_i;
    logic z_priority_i;
    logic busy_o;

    redmule_tcdm_arbiter_if #(.DW(DW), .AW(AW)) strm_if ();
    redmule_tcdm_mem_if     #(.DW(DW), .AW(AW)) tcdm_if ();

    redmule_tcdm_arbiter #(
        .DW(DW), .AW(AW), .MAX_OUTST(4), .Z_STARVE(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .z_priority_i (z_priority_i),
        .strm_if      (strm_if),
        .tcdm_if      (tcdm_if),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] data;
    } mem_t;

    exp_t expQ[$];
    mem_t memQ[$];
    int   cyc = 0;
    int   lat = 1;
    bit   rvEn = 1'b1;
    int   passCount = 0;
    int   failCount = 0;
    int   checkCount = 0;

    function automatic logic [DW-1:0] mkData(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [AW-1:0] addrOf(input int id);
        case (id)
            0:       return ADDR_X;
            1:       return ADDR_W;
            2:       return ADDR_Y;
            default: return ADDR_Z;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, model the memory, advance.
    // expWin: 0..2 load, 3 store, 4 no request on the port. expBusy: -1 means unchecked.
    task automatic applyStimulus(input logic [2:0] ldReq, input logic zReq, input logic zPrio,
                                 input logic gnt, input logic clr, input int expWin,
                                 input int expBusy);
        exp_t e;
        strm_if.ld_req = ldReq;
        strm_if.z_req  = zReq;
        z_priority_i   = zPrio;
        tcdm_if.gnt    = gnt;
        clear_i        = clr;
        if (expWin < 4 && gnt) begin
            expQ.push_back('{id: 2'(expWin),
                             data: (expWin == 3) ? '0 : mkData(addrOf(expWin))});
        end
        @(negedge clk_i);
        checkOutput("tcdm_req", 64'(tcdm_if.req), 64'(expWin < 4));
        checkOutput("ld_gnt", 64'(strm_if.ld_gnt),
                    (expWin < 3 && gnt) ? (64'(1) << expWin) : 64'(0));
        checkOutput("z_gnt", 64'(strm_if.z_gnt), 64'(expWin == 3 && gnt));
        if (expWin < 4) begin
            checkOutput("tcdm_add", 64'(tcdm_if.add), 64'(addrOf(expWin)));
            checkOutput("tcdm_wen", 64'(tcdm_if.wen), 64'(expWin != 3));
            checkOutput("tcdm_be", 64'(tcdm_if.be), (expWin == 3) ? 64'(Z_BE) : 64'hF);
            if (expWin == 3) begin
                checkOutput("tcdm_data", 64'(tcdm_if.data), 64'(Z_DATA));
            end
        end
        if (expBusy >= 0) begin
            checkOutput("busy", 64'(busy_o), 64'(expBusy));
        end
        if (tcdm_if.rvalid) begin
            checkOutput("rsp_expected", 64'(expQ.size() != 0), 64'(1));
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("ld_rvalid", 64'(strm_if.ld_rvalid),
                            (e.id == 2'd3) ? 64'(0) : (64'(1) << e.id));
                if (e.id != 2'd3) begin
                    checkOutput("ld_rdata", 64'(strm_if.ld_rdata), 64'(e.data));
                end
            end
        end else begin
            checkOutput("ld_rvalid_idle", 64'(strm_if.ld_rvalid), 64'(0));
        end
        if (tcdm_if.req && tcdm_if.gnt) begin
            memQ.push_back('{due: 32'(cyc + lat),
                             data: tcdm_if.wen ? mkData(tcdm_if.add) : '0});
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (rvEn && memQ.size() != 0 && int'(memQ[0].due) <= cyc) begin
            tcdm_if.rvalid = 1'b1;
            tcdm_if.rdata  = memQ[0].data;
            void'(memQ.pop_front());
        end else begin
            tcdm_if.rvalid = 1'b0;
            tcdm_if.rdata  = '0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4, -1);
        end
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));
    endtask

    initial begin
        rst_i           = 1'b1;
        clear_i         = 1'b0;
        z_priority_i    = 1'b0;
        strm_if.ld_req  = 3'b000;
        strm_if.ld_addr = {ADDR_Y, ADDR_W, ADDR_X};
        strm_if.z_req   = 1'b0;
        strm_if.z_addr  = ADDR_Z;
        strm_if.z_data  = Z_DATA;
        strm_if.z_be    = Z_BE;
        tcdm_if.gnt     = 1'b0;
        tcdm_if.rvalid  = 1'b0;
        tcdm_if.rdata   = '0;
        @(posedge clk_i);
        #1;

        // Reset holds every grant and the port quiet even with all requesters active.
        applyStimulus(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0);
        applyStimulus(3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 4, 0);
        checkOutput("rst_add", 64'(tcdm_if.add), 64'(0));
        checkOutput("rst_be", 64'(tcdm_if.be), 64'(0));
        rst_i = 1'b0;

        $display("[TB] round-robin loads");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, i % 3, -1);
        end
        idleCycles(2);

        $display("[TB] Z priority");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 3, -1);
        end
        idleCycles(2);

        $display("[TB] Z anti-starvation");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);
        end
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3, -1);
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);
        idleCycles(2);

        $display("[TB] outstanding limit");
        rvEn = 1'b0;
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1, -1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1, -1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
        end
        rvEn = 1'b1;
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
        idleCycles(4);

        $display("[TB] store then load, two-cycle latency");
        lat = 2;
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3, -1);
        applyStimulus(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
        idleCycles(4);
        lat = 1;

        $display("[TB] soft clear with three in flight");
        rvEn = 1'b0;
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        applyStimulus(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        applyStimulus(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1);
        rvEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
        end
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        idleCycles(2);

        $display("[TB] reset with a transaction in flight");
        rvEn = 1'b0;
        applyStimulus(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        rst_i = 1'b1;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
        memQ.delete();
        expQ.delete();
        rst_i = 1'b0;
        rvEn  = 1'b1;
        applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        idleCycles(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
